// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage in front of a registered-read register file.
// Accepts decoded fields, issues RF read addresses, resolves operands one
// cycle later (with write-back bypass), and presents a packet to EX under
// valid/ready. A per-register scoreboard stalls issue on RAW/WAW hazards
// against destinations still in flight.
module id_operand_stage #(
    parameter int unsigned ADDR   = 5,
    parameter int unsigned SIZE   = 32,
    parameter int unsigned CTRL_W = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              flush,
    // IF/ID side
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR-1:0]   in_rs,
    input  logic [ADDR-1:0]   in_rt,
    input  logic [ADDR-1:0]   in_rd,
    input  logic              in_use_rs,
    input  logic              in_use_rt,
    input  logic              in_we,
    input  logic [SIZE-1:0]   in_imm,
    input  logic [CTRL_W-1:0] in_ctrl,
    // Register file read port
    output logic [ADDR-1:0]   rf_ra,
    output logic [ADDR-1:0]   rf_rb,
    input  logic [SIZE-1:0]   rf_busA,
    input  logic [SIZE-1:0]   rf_busB,
    // Write-back
    input  logic              wb_we,
    input  logic [ADDR-1:0]   wb_rw,
    input  logic [SIZE-1:0]   wb_data,
    // EX side
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SIZE-1:0]   out_a,
    output logic [SIZE-1:0]   out_b,
    output logic [SIZE-1:0]   out_imm,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [ADDR-1:0]   out_rd,
    output logic              out_we
);

    localparam int unsigned NUMB = 1 << ADDR;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              out_valid_d;
    logic [NUMB-1:0]   sb_q, sb_d, sb_eff;

    // Fields of the instruction currently held in the stage
    logic [ADDR-1:0]   rd_q;
    logic              we_q;
    logic [SIZE-1:0]   imm_q;
    logic [CTRL_W-1:0] ctrl_q;

    // Write-back data seen in the accept cycle, before the RF can return it
    logic              fwd_a_q, fwd_b_q;
    logic [SIZE-1:0]   fwd_a_data_q, fwd_b_data_q;

    logic              stage_free;
    logic              hazard;
    logic              accept;
    logic              squash;
    logic              wb_hit_in_rs, wb_hit_in_rt;
    logic              wb_hit_ra, wb_hit_rb;
    logic [SIZE-1:0]   opnd_a, opnd_b;

    // Scoreboard as seen by this cycle's hazard check: a write-back landing
    // now already releases its register.
    always_comb begin
        sb_eff = sb_q;
        if (wb_we) begin
            sb_eff[wb_rw] = 1'b0;
        end
    end

    assign hazard = (in_use_rs & sb_eff[in_rs]) |
                    (in_use_rt & sb_eff[in_rt]) |
                    (in_we     & sb_eff[in_rd]);

    // The stage can take a new instruction when empty, or when the packet it
    // presents is being consumed this very cycle.
    assign stage_free = (state_q == IDLE) | ((state_q == HOLD) & out_ready);
    assign in_ready   = stage_free & ~hazard & ~flush;
    assign accept     = in_valid & in_ready;

    // A flush only kills an instruction that has not been handed to EX; a
    // packet completing its handshake in the flush cycle is already gone.
    assign squash = flush & ((state_q == READ) | ((state_q == HOLD) & ~out_ready));

    // Register 0 is hardwired, so it never matches for forwarding
    assign wb_hit_in_rs = wb_we & (wb_rw == in_rs) & (in_rs != '0);
    assign wb_hit_in_rt = wb_we & (wb_rw == in_rt) & (in_rt != '0);
    assign wb_hit_ra    = wb_we & (wb_rw == rf_ra) & (rf_ra != '0);
    assign wb_hit_rb    = wb_we & (wb_rw == rf_rb) & (rf_rb != '0);

    // Operand resolution during READ: zero reg, then data saved at accept,
    // then a write-back landing now, then the register file.
    always_comb begin
        if (rf_ra == '0) begin
            opnd_a = '0;
        end else if (fwd_a_q) begin
            opnd_a = fwd_a_data_q;
        end else if (wb_hit_ra) begin
            opnd_a = wb_data;
        end else begin
            opnd_a = rf_busA;
        end

        if (rf_rb == '0) begin
            opnd_b = '0;
        end else if (fwd_b_q) begin
            opnd_b = fwd_b_data_q;
        end else if (wb_hit_rb) begin
            opnd_b = wb_data;
        end else begin
            opnd_b = rf_busB;
        end
    end

    // Scoreboard next state; a set from a new issue overrides a same-cycle clear
    always_comb begin
        sb_d = sb_q;
        if (wb_we) begin
            sb_d[wb_rw] = 1'b0;
        end
        if (squash && we_q) begin
            sb_d[rd_q] = 1'b0;
        end
        if (accept && in_we && (in_rd != '0)) begin
            sb_d[in_rd] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    // Control FSM: IDLE -> READ (one cycle) -> HOLD until EX takes the packet
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid;
        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = READ;
                    end
                end
                READ: begin
                    state_d     = HOLD;
                    out_valid_d = 1'b1;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = accept ? READ : IDLE;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // FSM state, output valid and scoreboard
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            sb_q      <= '0;
        end else begin
            state_q   <= state_d;
            out_valid <= out_valid_d;
            sb_q      <= sb_d;
        end
    end

    // Capture the accepted instruction and drive the RF read addresses
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rf_ra        <= '0;
            rf_rb        <= '0;
            rd_q         <= '0;
            we_q         <= 1'b0;
            imm_q        <= '0;
            ctrl_q       <= '0;
            fwd_a_q      <= 1'b0;
            fwd_b_q      <= 1'b0;
            fwd_a_data_q <= '0;
            fwd_b_data_q <= '0;
        end else if (accept) begin
            rf_ra        <= in_rs;
            rf_rb        <= in_rt;
            rd_q         <= in_rd;
            we_q         <= in_we;
            imm_q        <= in_imm;
            ctrl_q       <= in_ctrl;
            fwd_a_q      <= wb_hit_in_rs;
            fwd_b_q      <= wb_hit_in_rt;
            fwd_a_data_q <= wb_data;
            fwd_b_data_q <= wb_data;
        end
    end

    // Build the EX packet at the end of READ; it then holds until replaced
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_a    <= '0;
            out_b    <= '0;
            out_imm  <= '0;
            out_ctrl <= '0;
            out_rd   <= '0;
            out_we   <= 1'b0;
        end else if ((state_q == READ) && !flush) begin
            out_a    <= opnd_a;
            out_b    <= opnd_b;
            out_imm  <= imm_q;
            out_ctrl <= ctrl_q;
            out_rd   <= rd_q;
            out_we   <= we_q;
        end
    end

endmodule
